// File: rtl/ras_pkg.sv
// ras_pkg: shared constants, FSM state encoding and the pointer-snapshot
// record for the return-address-stack controller.
package ras_pkg;

  localparam int DEPTH  = 32;          // RAS entries (power of 2)
  localparam int PTR_W  = 5;           // log2(DEPTH)
  localparam int CKPT   = 4;           // in-flight checkpoint slots (power of 2)
  localparam int CKPT_W = 2;           // log2(CKPT)

  // Saturation value for the live-entry counter.
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // Pointer state captured at checkpoint allocation.
  typedef struct packed {
    logic [PTR_W-1:0] tos;
    logic [PTR_W:0]   count;
  } snap_t;

endpackage

// File: rtl/ras_stack_mem.sv
// ras_stack_mem: DEPTH x 32 return-address storage.
// Ports:
//   CLK      clock
//   wr_en    write strobe
//   wr_addr  write slot
//   wr_data  write data
//   rd_addr  read slot (top of stack, tos-1)
//   rd_data  combinational read data (reflects contents before this edge's write)
// Storage is deliberately not reset; the controller zero-sweeps it after reset.
module ras_stack_mem
  import ras_pkg::*;
(
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: sequences a circular return-address stack for the fetch-stage
// predictor. Arbitrates ID push, IF pop and EX resolve into one tos/count
// state, and keeps an in-order queue of pointer snapshots for rollback.
// Ports:
//   CLK, RESET                     clock, async active-high reset
//   push_valid/push_addr           ID-stage link push
//   pop_valid/pop_ready            IF-stage JR $ra pop handshake
//   pred_valid/pred_pc             registered prediction (one pulse per pop)
//   ckpt_alloc/ckpt_tag/ckpt_full  checkpoint allocation
//   resolve_valid/_tag/_mispredict EX resolution of the oldest checkpoint
//   count                          live entries 0..DEPTH
//   order_err                      sticky out-of-order / empty resolve flag
module ras_ctrl
  import ras_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push_valid,
  input  logic [31:0]       push_addr,
  input  logic              pop_valid,
  output logic              pop_ready,
  output logic              pred_valid,
  output logic [31:0]       pred_pc,
  input  logic              ckpt_alloc,
  output logic [CKPT_W-1:0] ckpt_tag,
  output logic              ckpt_full,
  input  logic              resolve_valid,
  input  logic [CKPT_W-1:0] resolve_tag,
  input  logic              resolve_mispredict,
  output logic [PTR_W:0]    count,
  output logic              order_err
);

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  sweep_reg;
  logic [PTR_W-1:0]  tos_reg, tos_next;
  logic [PTR_W:0]    count_reg, count_next;
  logic [CKPT_W-1:0] head_reg, head_next, tail_reg, tail_next;
  logic [CKPT_W:0]   used_reg, used_next;
  logic              pred_valid_reg, pred_valid_next;
  logic [31:0]       pred_pc_reg, pred_pc_next;
  logic              order_err_reg, order_err_next;
  logic              pop_ready_reg;

  snap_t             ckpt_slot [CKPT];
  snap_t             snap_wr, snap_head;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata, mem_rdata;

  logic              run, res_hit, do_mispredict, do_commit, normal;
  logic              pop_acc, do_pop_hit, do_push, do_alloc;
  logic [PTR_W-1:0]  tos_after_pop, tos_after_push;
  logic [PTR_W:0]    count_after_pop, count_after_push;

  assign ckpt_full = (used_reg == (CKPT_W+1)'(CKPT));
  assign ckpt_tag  = tail_reg;
  assign snap_head = ckpt_slot[head_reg];

  ras_stack_mem u_mem (
    .CLK     (CLK),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_addr (tos_reg - PTR_W'(1)),
    .rd_data (mem_rdata)
  );

  always_comb begin
    run           = (state_reg == ST_RUN);
    res_hit       = resolve_valid && (used_reg != '0) && (resolve_tag == head_reg);
    do_mispredict = run && res_hit && resolve_mispredict;
    do_commit     = run && res_hit && !resolve_mispredict;
    // A mispredict squashes every other same-cycle request. An order error
    // only raises the flag; the other requests still proceed.
    normal        = run && !do_mispredict;

    // Pop first, then push onto the result, then snapshot the result.
    pop_acc         = normal && pop_valid;
    do_pop_hit      = pop_acc && (count_reg != '0);
    tos_after_pop   = do_pop_hit ? tos_reg - PTR_W'(1) : tos_reg;
    count_after_pop = do_pop_hit ? count_reg - (PTR_W+1)'(1) : count_reg;

    do_push          = normal && push_valid;
    tos_after_push   = do_push ? tos_after_pop + PTR_W'(1) : tos_after_pop;
    count_after_push = (do_push && (count_after_pop != CNT_FULL))
                       ? count_after_pop + (PTR_W+1)'(1) : count_after_pop;

    do_alloc      = normal && ckpt_alloc && !ckpt_full;
    snap_wr.tos   = tos_after_push;
    snap_wr.count = count_after_push;

    tos_next   = do_mispredict ? snap_head.tos   : tos_after_push;
    count_next = do_mispredict ? snap_head.count : count_after_push;

    head_next = do_mispredict ? '0 : (do_commit ? head_reg + CKPT_W'(1) : head_reg);
    tail_next = do_mispredict ? '0 : (do_alloc  ? tail_reg + CKPT_W'(1) : tail_reg);
    used_next = do_mispredict ? '0
              : used_reg + (CKPT_W+1)'(do_alloc) - (CKPT_W+1)'(do_commit);

    order_err_next  = order_err_reg | (run && resolve_valid && !res_hit);
    pred_valid_next = do_pop_hit;
    pred_pc_next    = do_pop_hit ? mem_rdata : (pop_acc ? 32'd0 : pred_pc_reg);

    // During INIT the write port is owned by the zero sweep.
    mem_we    = (state_reg == ST_INIT) ? 1'b1      : do_push;
    mem_waddr = (state_reg == ST_INIT) ? sweep_reg : tos_after_pop;
    mem_wdata = (state_reg == ST_INIT) ? 32'd0     : push_addr;

    state_next = state_reg;
    case (state_reg)
      ST_INIT:    if (sweep_reg == PTR_W'(DEPTH-1)) state_next = ST_RUN;
      ST_RUN:     if (do_mispredict) state_next = ST_RECOVER;
      ST_RECOVER: state_next = ST_RUN;
      default:    state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= ST_INIT;
      sweep_reg      <= '0;
      tos_reg        <= '0;
      count_reg      <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      used_reg       <= '0;
      pred_valid_reg <= 1'b0;
      pred_pc_reg    <= '0;
      order_err_reg  <= 1'b0;
      pop_ready_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sweep_reg      <= (state_reg == ST_INIT) ? sweep_reg + PTR_W'(1) : '0;
      tos_reg        <= tos_next;
      count_reg      <= count_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      used_reg       <= used_next;
      pred_valid_reg <= pred_valid_next;
      pred_pc_reg    <= pred_pc_next;
      order_err_reg  <= order_err_next;
      pop_ready_reg  <= (state_next == ST_RUN);
    end
  end

  // Snapshot slots hold data only; validity is tracked by head/tail/used.
  always_ff @(posedge CLK) begin
    if (do_alloc) ckpt_slot[tail_reg] <= snap_wr;
  end

  assign pop_ready  = pop_ready_reg;
  assign pred_valid = pred_valid_reg;
  assign pred_pc    = pred_pc_reg;
  assign count      = count_reg;
  assign order_err  = order_err_reg;

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: table-driven bench for ras_ctrl. Each vector drives one cycle;
// its expectations go into a scoreboard queue and are popped and compared
// after the clock edge that produces them.
module tb_ras_ctrl;
  import ras_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              push_valid = 1'b0;
  logic [31:0]       push_addr = '0;
  logic              pop_valid = 1'b0;
  logic              pop_ready;
  logic              pred_valid;
  logic [31:0]       pred_pc;
  logic              ckpt_alloc = 1'b0;
  logic [CKPT_W-1:0] ckpt_tag;
  logic              ckpt_full;
  logic              resolve_valid = 1'b0;
  logic [CKPT_W-1:0] resolve_tag = '0;
  logic              resolve_mispredict = 1'b0;
  logic [PTR_W:0]    count;
  logic              order_err;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  always #5 CLK = ~CLK;

  ras_ctrl dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .push_valid         (push_valid),
    .push_addr          (push_addr),
    .pop_valid          (pop_valid),
    .pop_ready          (pop_ready),
    .pred_valid         (pred_valid),
    .pred_pc            (pred_pc),
    .ckpt_alloc         (ckpt_alloc),
    .ckpt_tag           (ckpt_tag),
    .ckpt_full          (ckpt_full),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .count              (count),
    .order_err          (order_err)
  );

  typedef struct {
    logic        push_v;
    logic [31:0] push_a;
    logic        pop_v;
    logic        alloc;
    logic        res_v;
    logic [1:0]  res_tag;
    logic        res_mis;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic        e_pv;
    logic [5:0]  e_cnt;
    logic        e_ready;
    logic        e_full;
    logic        e_err;
    logic        chk_tag;
    logic [1:0]  e_tag;
  } vec_t;

  vec_t sb[$];

  function automatic vec_t mk(logic pu, logic [31:0] pa, logic po, logic al,
                              logic rv, logic [1:0] rt, logic rm,
                              logic cpc, logic [31:0] epc, logic epv,
                              logic [5:0] ecnt, logic erdy, logic efull,
                              logic eerr, logic ctag, logic [1:0] etag);
    vec_t v;
    v.push_v = pu;  v.push_a = pa;  v.pop_v = po;  v.alloc = al;
    v.res_v = rv;   v.res_tag = rt; v.res_mis = rm;
    v.chk_pc = cpc; v.e_pc = epc;   v.e_pv = epv;  v.e_cnt = ecnt;
    v.e_ready = erdy; v.e_full = efull; v.e_err = eerr;
    v.chk_tag = ctag; v.e_tag = etag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    vec_t e;
    push_valid = v.push_v;  push_addr = v.push_a;  pop_valid = v.pop_v;
    ckpt_alloc = v.alloc;   resolve_valid = v.res_v;
    resolve_tag = v.res_tag; resolve_mispredict = v.res_mis;
    if (v.chk_tag) chk({name, "/tag"}, 32'(ckpt_tag), 32'(v.e_tag));
    sb.push_back(v);
    @(posedge CLK); #1;
    push_valid = 0; pop_valid = 0; ckpt_alloc = 0; resolve_valid = 0; resolve_mispredict = 0;
    e = sb.pop_front();
    chk({name, "/pv"},    32'(pred_valid), 32'(e.e_pv));
    if (e.chk_pc) chk({name, "/pc"}, pred_pc, e.e_pc);
    chk({name, "/count"}, 32'(count),     32'(e.e_cnt));
    chk({name, "/ready"}, 32'(pop_ready), 32'(e.e_ready));
    chk({name, "/full"},  32'(ckpt_full), 32'(e.e_full));
    chk({name, "/err"},   32'(order_err), 32'(e.e_err));
    txn++;
    $display("txn %0d %s push=%0b/%0h pop=%0b alloc=%0b res=%0b/%0d/%0b -> pv=%0b pc=%0h cnt=%0d rdy=%0b full=%0b err=%0b",
             txn, name, e.push_v, e.push_a, e.pop_v, e.alloc, e.res_v, e.res_tag, e.res_mis,
             pred_valid, pred_pc, count, pop_ready, ckpt_full, order_err);
  endtask

  // Release reset and walk the 32-cycle sweep with pop/push held high.
  task automatic reset_and_init();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("rst/ready", 32'(pop_ready), 32'd0);
    chk("rst/count", 32'(count), 32'd0);
    chk("rst/pv",    32'(pred_valid), 32'd0);
    chk("rst/pc",    pred_pc, 32'd0);
    chk("rst/err",   32'(order_err), 32'd0);
    chk("rst/full",  32'(ckpt_full), 32'd0);
    chk("rst/tag",   32'(ckpt_tag), 32'd0);
    pop_valid = 1; push_valid = 1; push_addr = 32'hDEAD;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("init%0d/ready", i), 32'(pop_ready), (i >= DEPTH) ? 32'd1 : 32'd0);
      chk($sformatf("init%0d/count", i), 32'(count), 32'd0);
    end
    push_valid = 0; pop_valid = 0;
  endtask

  vec_t tab_a[13];
  vec_t tab_b[7];
  vec_t tab_c[10];

  initial begin
    // push/pop ordering, empty pops, same-cycle push+pop
    tab_a[0]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0);
    tab_a[1]  = mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0,       0, 2, 1, 0, 0, 0, 0);
    tab_a[2]  = mk(1, 32'h300, 0, 0, 0, 0, 0, 0, 0,       0, 3, 1, 0, 0, 0, 0);
    tab_a[3]  = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'h300, 1, 2, 1, 0, 0, 0, 0);
    tab_a[4]  = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'h200, 1, 1, 1, 0, 0, 0, 0);
    tab_a[5]  = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'h100, 1, 0, 1, 0, 0, 0, 0);
    tab_a[6]  = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'h0,   0, 0, 1, 0, 0, 0, 0);
    tab_a[7]  = mk(0, 0,       0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 0, 0, 0);
    tab_a[8]  = mk(1, 32'hA0,  0, 0, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0);
    tab_a[9]  = mk(1, 32'hB0,  1, 0, 0, 0, 0, 1, 32'hA0,  1, 1, 1, 0, 0, 0, 0);
    tab_a[10] = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'hB0,  1, 0, 1, 0, 0, 0, 0);
    tab_a[11] = mk(1, 32'hC0,  1, 0, 0, 0, 0, 1, 32'h0,   0, 1, 1, 0, 0, 0, 0);
    tab_a[12] = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'hC0,  1, 0, 1, 0, 0, 0, 0);
    // checkpoint + mispredict rollback; requests during resolve/RECOVER ignored
    tab_b[0]  = mk(1, 32'h40,  0, 0, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0);
    tab_b[1]  = mk(0, 0,       0, 1, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 1, 0);
    tab_b[2]  = mk(1, 32'h50,  0, 0, 0, 0, 0, 0, 0,       0, 2, 1, 0, 0, 0, 0);
    tab_b[3]  = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'h50,  1, 1, 1, 0, 0, 0, 0);
    tab_b[4]  = mk(1, 32'h77,  1, 1, 1, 0, 1, 0, 0,       0, 1, 0, 0, 0, 0, 0);
    tab_b[5]  = mk(1, 32'h99,  1, 1, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0);
    tab_b[6]  = mk(0, 0,       1, 0, 0, 0, 0, 1, 32'h40,  1, 0, 1, 0, 0, 0, 0);
    // fill the checkpoint queue, drop on full, out-of-order resolve
    tab_c[0]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tab_c[1]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tab_c[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tab_c[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 3);
    tab_c[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tab_c[5]  = mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    tab_c[6]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tab_c[7]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    tab_c[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
    tab_c[9]  = mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

    reset_and_init();
    // first pop after INIT misses on an empty stack
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "firstpop");

    for (int i = 0; i < 13; i++) run_vec(tab_a[i], $sformatf("A%0d", i));

    // overflow: 33 pushes overwrite the oldest entry
    for (int i = 0; i < DEPTH + 1; i++)
      run_vec(mk(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0, 0,
                 6'((i + 1 > DEPTH) ? DEPTH : i + 1), 1, 0, 0, 0, 0),
              $sformatf("ovpush%0d", i));
    for (int j = 0; j < DEPTH; j++)
      run_vec(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1080 - 32'(4 * j), 1,
                 6'(DEPTH - 1 - j), 1, 0, 0, 0, 0),
              $sformatf("ovpop%0d", j));
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "ovpop_miss");

    for (int i = 0; i < 7; i++)  run_vec(tab_b[i], $sformatf("B%0d", i));
    for (int i = 0; i < 10; i++) run_vec(tab_c[i], $sformatf("C%0d", i));

    // reset in the middle of INIT restarts the full sweep
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    chk("midinit/ready", 32'(pop_ready), 32'd0);
    @(negedge CLK);
    reset_and_init();

    // resolve with an empty checkpoint queue is an order error
    run_vec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), "emptyres");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
